// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: RV32I opcodes, state
// encoding and datapath select codes.
package multicycle_control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_FAULT    = 4'd15
  } cfsm_state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_PASSB = 3'b011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the wait that would reach
// the timeout limit, so the FSM can leave for FAULT on that same edge.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  // Any non-wait cycle is either a completion or a non-memory state, so
  // clearing here also clears on entry to every memory state.
  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (waiting) count <= count + CW'(1);
    else              count <= '0;
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = waiting && (count == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM with memory ready handshake, wait timeout,
// illegal-opcode trapping and a sticky FAULT state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_HANDSHAKE  = 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TRAP_ILLEGAL   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       PCUpdate,
  output logic       MemWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [3:0] FSMState,
  output logic       illegal_instr,
  output logic       fault
);

  cfsm_state_t state, state_next;
  logic       mem_done, waiting, expired;
  logic       req_c, adr_c, irw_c, rw_c, pcu_c, mw_c, br_c, ill_c, flt_c;
  logic [1:0] srca_c, srcb_c, res_c;
  logic [2:0] aluop_c;

  assign mem_done = (MEM_HANDSHAKE == 0) || mem_ready;
  assign waiting  = req_c && !mem_done;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_c   = 1'b0;  adr_c = 1'b0;  irw_c = 1'b0;  rw_c  = 1'b0;
    pcu_c   = 1'b0;  mw_c  = 1'b0;  br_c  = 1'b0;  ill_c = 1'b0;
    flt_c   = 1'b0;
    srca_c  = SRCA_PC;
    srcb_c  = SRCB_RS2;
    aluop_c = ALUOP_ADD;
    res_c   = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        req_c  = 1'b1;
        srcb_c = SRCB_FOUR;
        res_c  = RES_ALURES;
        if (mem_done) begin
          irw_c      = 1'b1;
          pcu_c      = 1'b1;
          state_next = S_DECODE;
        end else if (expired) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        srca_c = SRCA_OLDPC;
        srcb_c = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default: begin
            ill_c      = 1'b1;
            state_next = (TRAP_ILLEGAL != 0) ? S_FAULT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        srca_c     = SRCA_RS1;
        srcb_c     = SRCB_IMM;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c = 1'b1;
        adr_c = 1'b1;
        if (mem_done)     state_next = S_MEMWB;
        else if (expired) state_next = S_FAULT;
      end
      S_MEMWB: begin
        rw_c       = 1'b1;
        res_c      = RES_RDATA;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c = 1'b1;
        adr_c = 1'b1;
        mw_c  = 1'b1;
        if (mem_done)     state_next = S_FETCH;
        else if (expired) state_next = S_FAULT;
      end
      S_EXECR, S_EXECI: begin
        aluop_c    = ALUOP_FUNCT;
        srca_c     = SRCA_RS1;
        srcb_c     = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c       = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        srca_c     = SRCA_RS1;
        aluop_c    = ALUOP_SUB;
        br_c       = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        pcu_c      = 1'b1;
        srca_c     = SRCA_OLDPC;
        srcb_c     = SRCB_FOUR;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        srca_c     = SRCA_RS1;
        srcb_c     = SRCB_IMM;
        pcu_c      = 1'b1;
        res_c      = RES_ALURES;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        srcb_c     = SRCB_IMM;
        aluop_c    = ALUOP_PASSB;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        srca_c     = SRCA_OLDPC;
        srcb_c     = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_FAULT: begin
        flt_c      = 1'b1;
        state_next = S_FAULT;
      end
      default: state_next = S_FAULT;
    endcase
  end

  // Reset silences every output, so an interrupted access never writes.
  assign mem_req       = req_c & ~reset;
  assign AdrSrc        = adr_c & ~reset;
  assign IRWrite       = irw_c & ~reset;
  assign RegWrite      = rw_c  & ~reset;
  assign PCUpdate      = pcu_c & ~reset;
  assign MemWrite      = mw_c  & ~reset;
  assign Branch        = br_c  & ~reset;
  assign illegal_instr = ill_c & ~reset;
  assign fault         = flt_c & ~reset;
  assign ALUSrcA       = reset ? 2'b00   : srca_c;
  assign ALUSrcB       = reset ? 2'b00   : srcb_c;
  assign ALUOp         = reset ? 3'b000  : aluop_c;
  assign ResultSrc     = reset ? 2'b00   : res_c;
  assign FSMState      = reset ? 4'b0000 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: a handshake/trap instance and
// a no-handshake, non-trapping instance.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [6:0] opcode;

  always #5 clk = ~clk;

  logic       a_req, a_adr, a_irw, a_rw, a_pcu, a_mw, a_br, a_ill, a_flt;
  logic [1:0] a_srca, a_srcb, a_res;
  logic [2:0] a_op;
  logic [3:0] a_st;
  logic       b_req, b_adr, b_irw, b_rw, b_pcu, b_mw, b_br, b_ill, b_flt;
  logic [1:0] b_srca, b_srcb, b_res;
  logic [2:0] b_op;
  logic [3:0] b_st;

  multicycle_control #(.MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(4), .TRAP_ILLEGAL(1)) u_a (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(a_req), .AdrSrc(a_adr), .IRWrite(a_irw), .RegWrite(a_rw),
    .PCUpdate(a_pcu), .MemWrite(a_mw), .Branch(a_br), .ALUSrcA(a_srca),
    .ALUSrcB(a_srcb), .ALUOp(a_op), .ResultSrc(a_res), .FSMState(a_st),
    .illegal_instr(a_ill), .fault(a_flt));

  multicycle_control #(.MEM_HANDSHAKE(0), .TIMEOUT_CYCLES(0), .TRAP_ILLEGAL(0)) u_b (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(b_req), .AdrSrc(b_adr), .IRWrite(b_irw), .RegWrite(b_rw),
    .PCUpdate(b_pcu), .MemWrite(b_mw), .Branch(b_br), .ALUSrcA(b_srca),
    .ALUSrcB(b_srcb), .ALUOp(b_op), .ResultSrc(b_res), .FSMState(b_st),
    .illegal_instr(b_ill), .fault(b_flt));

  // Output bundle: {req,adr,irw,rw,pcu,mw,br, srcA, srcB, aluop, res, state, ill, fault}
  logic [21:0] act_a, act_b;
  assign act_a = {a_req, a_adr, a_irw, a_rw, a_pcu, a_mw, a_br, a_srca, a_srcb,
                  a_op, a_res, a_st, a_ill, a_flt};
  assign act_b = {b_req, b_adr, b_irw, b_rw, b_pcu, b_mw, b_br, b_srca, b_srcb,
                  b_op, b_res, b_st, b_ill, b_flt};

  localparam logic [6:0] OP_L = 7'b0000011, OP_S = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_B = 7'b1100011, OP_J = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111, OP_LU = 7'b0110111, OP_AU = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  opc;
    logic        rdy;
    logic [21:0] want;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [21:0] E_F1, E_F0, E_DEC, E_DILL, E_MA, E_MR, E_MWB, E_MW, E_XR, E_XI;
  logic [21:0] E_WB, E_BR, E_JAL, E_JALR, E_LUI, E_AUI, E_FLT;

  function automatic logic [21:0] ov(input logic [3:0] st, input logic [6:0] strb,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] op, input logic [1:0] rs,
                                     input logic ill, input logic flt);
    return {strb, a, b, op, rs, st, ill, flt};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic cyc(input logic [6:0] op, input logic rdy, input logic rst);
    opcode    = op;
    mem_ready = rdy;
    reset     = rst;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [6:0] op, input logic rdy, input logic [21:0] want);
    vecs.push_back('{opc: op, rdy: rdy, want: want});
  endtask

  task automatic do_reset;
    cyc(OP_R, 1'b0, 1'b1);
    nxt();
  endtask

  initial begin
    logic [21:0] b_seq [5];

    // strobes: req adr irw rw pcu mw br
    E_F1   = ov(4'd0,  7'b1010100, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0);
    E_F0   = ov(4'd0,  7'b1000000, 2'b00, 2'b10, 3'b000, 2'b10, 1'b0, 1'b0);
    E_DEC  = ov(4'd1,  7'b0000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
    E_DILL = ov(4'd1,  7'b0000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b1, 1'b0);
    E_MA   = ov(4'd2,  7'b0000000, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
    E_MR   = ov(4'd3,  7'b1100000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    E_MWB  = ov(4'd4,  7'b0001000, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
    E_MW   = ov(4'd5,  7'b1100010, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    E_XR   = ov(4'd6,  7'b0000000, 2'b10, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0);
    E_XI   = ov(4'd7,  7'b0000000, 2'b10, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0);
    E_WB   = ov(4'd8,  7'b0001000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    E_BR   = ov(4'd9,  7'b0000001, 2'b10, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0);
    E_JAL  = ov(4'd10, 7'b0000100, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0);
    E_JALR = ov(4'd11, 7'b0000100, 2'b10, 2'b01, 3'b000, 2'b10, 1'b0, 1'b0);
    E_LUI  = ov(4'd12, 7'b0000000, 2'b00, 2'b01, 3'b011, 2'b00, 1'b0, 1'b0);
    E_AUI  = ov(4'd13, 7'b0000000, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
    E_FLT  = ov(4'd15, 7'b0000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);

    add(OP_R, 1, E_F1);  add(OP_R, 0, E_DEC);  add(OP_R, 0, E_XR);  add(OP_R, 0, E_WB);
    add(OP_I, 1, E_F1);  add(OP_I, 0, E_DEC);  add(OP_I, 0, E_XI);  add(OP_I, 0, E_WB);
    add(OP_L, 1, E_F1);  add(OP_L, 0, E_DEC);  add(OP_L, 0, E_MA);
    add(OP_L, 0, E_MR);  add(OP_L, 0, E_MR);   add(OP_L, 0, E_MR);  add(OP_L, 1, E_MR);
    add(OP_L, 0, E_MWB);
    add(OP_S, 0, E_F0);  add(OP_S, 1, E_F1);   add(OP_S, 0, E_DEC); add(OP_S, 0, E_MA);
    add(OP_S, 0, E_MW);  add(OP_S, 1, E_MW);
    add(OP_B, 1, E_F1);  add(OP_B, 0, E_DEC);  add(OP_B, 0, E_BR);
    add(OP_J, 1, E_F1);  add(OP_J, 0, E_DEC);  add(OP_J, 0, E_JAL);  add(OP_J, 0, E_WB);
    add(OP_JR, 1, E_F1); add(OP_JR, 0, E_DEC); add(OP_JR, 0, E_JALR); add(OP_JR, 0, E_WB);
    add(OP_LU, 1, E_F1); add(OP_LU, 0, E_DEC); add(OP_LU, 0, E_LUI); add(OP_LU, 0, E_WB);
    add(OP_AU, 1, E_F1); add(OP_AU, 0, E_DEC); add(OP_AU, 0, E_AUI); add(OP_AU, 0, E_WB);
    add(OP_R, 1, E_F1);

    reset = 1'b1; opcode = OP_R; mem_ready = 1'b0;
    nxt();
    cyc(OP_R, 1'b1, 1'b1);
    check("reset_a", act_a, 22'd0);
    check("reset_b", act_b, 22'd0);
    nxt();

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].opc, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d", i), act_a, vecs[i].want);
      nxt();
    end

    // Fetch timeout after 4 wait cycles, sticky fault, then recovery by reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(OP_R, 1'b0, 1'b0);
      check($sformatf("tmo_wait%0d", i), act_a, E_F0);
      nxt();
    end
    cyc(OP_R, 1'b0, 1'b0); check("tmo_fault", act_a, E_FLT); nxt();
    cyc(OP_R, 1'b1, 1'b0); check("fault_sticky", act_a, E_FLT); nxt();
    cyc(OP_R, 1'b1, 1'b1); check("fault_reset", act_a, 22'd0); nxt();
    cyc(OP_R, 1'b1, 1'b0); check("after_reset", act_a, E_F1); nxt();

    // Completion on the cycle the limit is reached beats the timeout.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(OP_R, 1'b0, 1'b0); nxt();
    end
    cyc(OP_R, 1'b1, 1'b0); check("win_done", act_a, E_F1); nxt();
    cyc(OP_R, 1'b0, 1'b0); check("win_decode", act_a, E_DEC); nxt();

    // Illegal opcode: trap on u_a, retire as NOP on u_b (handshake ignored).
    do_reset();
    cyc(OP_BAD, 1'b0, 1'b0);
    check("ill_a_fetch_wait", act_a, E_F0);
    check("ill_b_fetch", act_b, E_F1);
    nxt();
    cyc(OP_BAD, 1'b1, 1'b0);
    check("ill_a_fetch", act_a, E_F1);
    check("ill_b_decode", act_b, E_DILL);
    nxt();
    cyc(OP_BAD, 1'b0, 1'b0);
    check("ill_a_decode", act_a, E_DILL);
    check("ill_b_refetch", act_b, E_F1);
    nxt();
    cyc(OP_BAD, 1'b0, 1'b0);
    check("ill_a_fault", act_a, E_FLT);
    nxt();

    // No-handshake instance runs an R-type in 4 cycles with mem_ready low.
    do_reset();
    b_seq[0] = E_F1; b_seq[1] = E_DEC; b_seq[2] = E_XR; b_seq[3] = E_WB; b_seq[4] = E_F1;
    for (int i = 0; i < 5; i++) begin
      cyc(OP_R, 1'b0, 1'b0);
      check($sformatf("nohs_add%0d", i), act_b, b_seq[i]);
      nxt();
    end

    // Reset during a stalled store abandons it without a write strobe.
    do_reset();
    cyc(OP_S, 1'b1, 1'b0); nxt();
    cyc(OP_S, 1'b0, 1'b0); nxt();
    cyc(OP_S, 1'b0, 1'b0); nxt();
    cyc(OP_S, 1'b0, 1'b0); check("st_memwrite", act_a, E_MW); nxt();
    cyc(OP_S, 1'b0, 1'b1); check("rst_memwrite", act_a, 22'd0); nxt();
    cyc(OP_S, 1'b0, 1'b0); check("rst_refetch", act_a, E_F0); nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
